// File: rtl/wrr_arb_n.sv
// Weighted round-robin arbiter with per-winner burst credits and packet-atomic hold.
// Priority rotates from sel+1 (mask + fallback encoder); grant, sel, credit and owner are registered.

module wrr_arb_lane #(
  parameter int INPUT_NBITS = 5,
  parameter int IDX         = 0
) (
  input  logic [INPUT_NBITS-1:0] i_sel,
  input  logic                   i_gnt,
  output logic                   o_is_sel,
  output logic                   o_above,
  output logic                   o_ack
);
  localparam logic [INPUT_NBITS-1:0] L_IDX = INPUT_NBITS'(IDX);

  assign o_is_sel = (i_sel == L_IDX);
  assign o_above  = (L_IDX > i_sel);
  assign o_ack    = i_gnt & o_is_sel;
endmodule

module wrr_arb_n #(
  parameter int NUM_OF_INPUT = 20,
  parameter int INPUT_NBITS  = 5,
  parameter int WEIGHT_NBITS = 4
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic [NUM_OF_INPUT-1:0]              req,
  input  logic [NUM_OF_INPUT-1:0]              hold,
  input  logic [NUM_OF_INPUT*WEIGHT_NBITS-1:0] weight,
  input  logic                                 en,
  output logic [NUM_OF_INPUT-1:0]              ack,
  output logic [INPUT_NBITS-1:0]               sel,
  output logic                                 gnt
);
  localparam logic [INPUT_NBITS-1:0]  L_SEL_RST = INPUT_NBITS'(NUM_OF_INPUT-1);
  localparam logic [WEIGHT_NBITS-1:0] L_ONE     = WEIGHT_NBITS'(1);

  logic [INPUT_NBITS-1:0]  r_sel, w_sel_nxt;
  logic                    r_gnt, w_gnt_nxt;
  logic                    r_own, w_own_nxt;
  logic [WEIGHT_NBITS-1:0] r_cnt, w_cnt_nxt;

  logic [NUM_OF_INPUT-1:0] w_is_sel, w_above, w_req_hi;
  logic                    w_hi_any, w_any, w_req_sel, w_hold_sel, w_keep;
  logic [INPUT_NBITS-1:0]  w_hi_idx, w_lo_idx, w_win_idx;
  logic [WEIGHT_NBITS-1:0] w_win_wt, w_weff;

  for (genvar g = 0; g < NUM_OF_INPUT; g++) begin : g_lane
    wrr_arb_lane #(.INPUT_NBITS(INPUT_NBITS), .IDX(g)) u_lane (
      .i_sel    (r_sel),
      .i_gnt    (r_gnt),
      .o_is_sel (w_is_sel[g]),
      .o_above  (w_above[g]),
      .o_ack    (ack[g])
    );
  end

  // Requests strictly above the pointer first; otherwise wrap to the lowest request,
  // which includes the current owner as the last candidate.
  assign w_req_hi = req & w_above;
  assign w_any    = |req;

  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_idx = '0;
    for (int i = NUM_OF_INPUT-1; i >= 0; i--) begin
      if (w_req_hi[i]) begin
        w_hi_any = 1'b1;
        w_hi_idx = INPUT_NBITS'(i);
      end
      if (req[i]) w_lo_idx = INPUT_NBITS'(i);
    end
  end

  assign w_win_idx = w_hi_any ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_win_wt = '0;
    for (int i = 0; i < NUM_OF_INPUT; i++)
      if (INPUT_NBITS'(i) == w_win_idx) w_win_wt = weight[i*WEIGHT_NBITS +: WEIGHT_NBITS];
  end

  assign w_weff     = (w_win_wt == '0) ? L_ONE : w_win_wt;
  assign w_req_sel  = |(req & w_is_sel);
  assign w_hold_sel = |(hold & w_is_sel);
  assign w_keep     = r_own & w_req_sel & ((r_cnt > L_ONE) | w_hold_sel);

  always_comb begin
    w_sel_nxt = r_sel;
    w_gnt_nxt = 1'b0;
    w_own_nxt = r_own;
    w_cnt_nxt = r_cnt;
    if (en) begin
      if (w_keep) begin
        w_gnt_nxt = 1'b1;
        if (r_cnt > L_ONE) w_cnt_nxt = r_cnt - L_ONE;
      end else if (w_any) begin
        w_sel_nxt = w_win_idx;
        w_gnt_nxt = 1'b1;
        w_own_nxt = 1'b1;
        w_cnt_nxt = w_weff;
      end else begin
        w_own_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sel <= L_SEL_RST;
      r_gnt <= 1'b0;
      r_own <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_sel <= w_sel_nxt;
      r_gnt <= w_gnt_nxt;
      r_own <= w_own_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign sel = r_sel;
  assign gnt = r_gnt;
endmodule

// File: tb/tb_wrr_arb_n.sv
// Scoreboard bench for wrr_arb_n: directed vectors push expected winners, per-DUT monitors pop on gnt.
// A 20-input instance covers rotation, weights, en and hold; a 6-input instance covers wrap and async reset.

module tb_wrr_arb_n;
  localparam int N   = 20;
  localparam int NB  = 5;
  localparam int WB  = 4;
  localparam int N6  = 6;
  localparam int NB6 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rstn, en, gnt;
  logic [N-1:0]     req, hold, ack;
  logic [N*WB-1:0]  weight;
  logic [NB-1:0]    sel;

  logic             rstn6, en6, gnt6;
  logic [N6-1:0]    req6, hold6, ack6;
  logic [N6*WB-1:0] weight6;
  logic [NB6-1:0]   sel6;

  int n_run  = 0;
  int n_fail = 0;
  int q[$];
  int q6[$];
  int e_m, e6_m;
  logic [N-1:0]  ea_m;
  logic [N6-1:0] ea6_m;

  wrr_arb_n #(.NUM_OF_INPUT(N), .INPUT_NBITS(NB), .WEIGHT_NBITS(WB)) u_dut (
    .clk(clk), .rstn(rstn), .req(req), .hold(hold), .weight(weight), .en(en),
    .ack(ack), .sel(sel), .gnt(gnt)
  );

  wrr_arb_n #(.NUM_OF_INPUT(N6), .INPUT_NBITS(NB6), .WEIGHT_NBITS(WB)) u_dut6 (
    .clk(clk), .rstn(rstn6), .req(req6), .hold(hold6), .weight(weight6), .en(en6),
    .ack(ack6), .sel(sel6), .gnt(gnt6)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_w(input int i, input int v);
    weight[i*WB +: WB] = WB'(v);
  endtask

  task automatic idle(input string nm, input int exp_sel);
    req = '0;
    step(1);
    chk({nm, "_idle_gnt"}, int'(gnt), 0);
    chk({nm, "_idle_ack"}, int'(ack), 0);
    chk({nm, "_idle_sel"}, int'(sel), exp_sel);
    chk({nm, "_drain"}, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rstn && gnt) begin
      if (q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_grant: sel %0d, no grant expected", sel);
      end else begin
        e_m = q.pop_front();
        ea_m = '0;
        ea_m[e_m] = 1'b1;
        chk("sel", int'(sel), e_m);
        chk("ack", int'(ack), int'(ea_m));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn6 && gnt6) begin
      if (q6.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_grant6: sel %0d, no grant expected", sel6);
      end else begin
        e6_m = q6.pop_front();
        ea6_m = '0;
        ea6_m[e6_m] = 1'b1;
        chk("sel6", int'(sel6), e6_m);
        chk("ack6", int'(ack6), int'(ea6_m));
      end
    end
  end

  initial begin
    rstn = 1'b0; en = 1'b1; req = '0; hold = '0;
    for (int i = 0; i < N; i++) set_w(i, 1);
    rstn6 = 1'b0; en6 = 1'b1; req6 = '0; hold6 = '0;
    for (int i = 0; i < N6; i++) weight6[i*WB +: WB] = WB'(1);
    step(2);
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_ack", int'(ack), 0);
    chk("rst_sel", int'(sel), N-1);
    chk("rst6_gnt", int'(gnt6), 0);
    chk("rst6_sel", int'(sel6), N6-1);
    rstn = 1'b1;
    rstn6 = 1'b1;

    // 1: all requesting, unit weights -> plain round robin from index 0
    req = '1;
    for (int i = 0; i < 22; i++) q.push_back(i % N);
    step(22);
    idle("t1", 1);

    // 2: weight 4 vs weight 1
    set_w(3, 4); set_w(7, 1);
    req[3] = 1'b1; req[7] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      q.push_back(3); q.push_back(3); q.push_back(3); q.push_back(3); q.push_back(7);
    end
    step(10);
    idle("t2", 7);

    // 3: zero weight behaves as one
    set_w(5, 0); set_w(6, 2);
    req[5] = 1'b1; req[6] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      q.push_back(5); q.push_back(6); q.push_back(6);
    end
    step(6);
    idle("t3", 6);

    // 4: en low freezes the burst credit
    set_w(2, 3); set_w(9, 1);
    req[2] = 1'b1;
    q.push_back(2);
    step(1);
    en = 1'b0;
    step(1);
    chk("t4_en0_gnt_a", int'(gnt), 0);
    step(1);
    chk("t4_en0_gnt_b", int'(gnt), 0);
    chk("t4_en0_ack", int'(ack), 0);
    en = 1'b1;
    req[9] = 1'b1;
    q.push_back(2); q.push_back(2); q.push_back(9);
    step(3);
    idle("t4", 9);

    // 5: hold keeps the owner past its credit; dropping req ends the burst
    set_w(4, 1); set_w(8, 1);
    hold[4] = 1'b1;
    req[4] = 1'b1; req[8] = 1'b1;
    for (int i = 0; i < 6; i++) q.push_back(4);
    step(6);
    hold[4] = 1'b0;
    q.push_back(8);
    step(1);
    set_w(4, 3);
    q.push_back(4); q.push_back(4);
    step(2);
    req[4] = 1'b0;
    q.push_back(8);
    step(1);
    idle("t5", 8);

    // 6: N=6 self re-win wrap, then async reset mid-burst
    weight6[5*WB +: WB] = WB'(2);
    req6[5] = 1'b1;
    for (int i = 0; i < 4; i++) q6.push_back(5);
    step(3);
    req6[0] = 1'b1;
    step(1);
    @(negedge clk);
    #1;
    rstn6 = 1'b0;
    #1;
    chk("t6_rst_gnt", int'(gnt6), 0);
    chk("t6_rst_ack", int'(ack6), 0);
    chk("t6_rst_sel", int'(sel6), N6-1);
    chk("t6_pre_drain", q6.size(), 0);
    step(1);
    rstn6 = 1'b1;
    q6.push_back(0);
    step(1);
    req6 = '0;
    step(1);
    chk("t6_idle_gnt", int'(gnt6), 0);
    chk("t6_idle_sel", int'(sel6), 0);
    chk("t6_drain", q6.size(), 0);

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
